// File: rtl/address_bus_pkg.sv
// rtl/address_bus_pkg.sv - memory map constants, FSM/region encodings and the address decode function
package address_bus_pkg;

    localparam logic [15:0] RAM_LIMIT  = 16'h3FFF;
    localparam logic [15:0] VRAM_BASE  = 16'h4000;
    localparam logic [15:0] VRAM_LIMIT = 16'h4FFF;
    localparam logic [15:0] FW_BASE    = 16'h5000;
    localparam logic [15:0] FW_LIMIT   = 16'h6FFF;
    localparam logic [15:0] IO_BASE    = 16'h7000;
    localparam logic [15:0] IO_IRQ     = 16'h7001;
    localparam logic [15:0] IO_CTRL    = 16'h7002;
    localparam logic [15:0] ROM_BASE   = 16'h8000;
    localparam logic [15:0] VEC_BASE   = 16'hFFFA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        REG_RAM  = 3'd0,
        REG_VRAM = 3'd1,
        REG_FW   = 3'd2,
        REG_IO   = 3'd3,
        REG_ROM  = 3'd4,
        REG_NONE = 3'd5
    } region_e;

    typedef struct packed {
        logic ram;
        logic vram;
        logic fw;
        logic rom;
        logic vec;
        logic io;
    } sel_t;

    // The IO window grows with the number of controller ports; everything
    // above it up to ROM_BASE is unmapped.
    function automatic region_e decode_region(input logic [15:0] addr, input int num_ctrl);
        if (addr <= RAM_LIMIT) begin
            return REG_RAM;
        end else if (addr <= VRAM_LIMIT) begin
            return REG_VRAM;
        end else if (addr <= FW_LIMIT) begin
            return REG_FW;
        end else if (addr < ROM_BASE) begin
            if (int'(addr) <= int'(IO_IRQ) + num_ctrl) begin
                return REG_IO;
            end
            return REG_NONE;
        end
        return REG_ROM;
    endfunction

endpackage

// File: rtl/ws_counter_m.sv
// rtl/ws_counter_m.sv - load/decrement wait-state counter saturating at zero
// Ports: clk, rst (async, active high), load_i/load_val_i (load a new count),
//        dec_i (decrement request), count_o (current count), zero_o (count is zero).
module ws_counter_m #(
    parameter int WS_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [WS_W-1:0] load_val_i,
    input  logic            dec_i,
    output logic [WS_W-1:0] count_o,
    output logic            zero_o
);

    logic [WS_W-1:0] count_q;
    logic [WS_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/address_bus_ws_m.sv
// rtl/address_bus_ws_m.sv - registered 6502 address decoder with per-region wait states, IO mux and vblank IRQ
// Ports: clk/rst (async, active high); cpu_address/cpu_rwb/cpu_req in, cpu_ack/io_rdata out;
//        vram_offset and SELECT_* registered region selects; in_vblank/vblank_start/controller_data
//        from PPU and pads; vblank_irq level IRQ. Optional bus_error output when
//        MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN is defined.
module address_bus_ws_m
    import address_bus_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WS_W     = 2,
    parameter int RAM_WS   = 0,
    parameter int VRAM_WS  = 1,
    parameter int FW_WS    = 0,
    parameter int IO_WS    = 0,
    parameter int ROM_WS   = 2,
    parameter int NUM_CTRL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic                  cpu_rwb,
    input  logic                  cpu_req,
    output logic                  cpu_ack,
    output logic [7:0]            io_rdata,
    output logic [11:0]           vram_offset,
    output logic                  SELECT_ram,
    output logic                  SELECT_vram,
    output logic                  SELECT_firmware,
    output logic                  SELECT_rom,
    output logic                  SELECT_vectors,
    output logic                  SELECT_io,
    input  logic                  in_vblank,
    input  logic                  vblank_start,
    input  logic [8*NUM_CTRL-1:0] controller_data,
`ifdef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
    output logic                  bus_error,
`endif
    output logic                  vblank_irq
);

    if ((RAM_WS >= (1 << WS_W)) || (VRAM_WS >= (1 << WS_W)) || (FW_WS >= (1 << WS_W)) ||
        (IO_WS >= (1 << WS_W)) || (ROM_WS >= (1 << WS_W))) begin : g_bad_ws
        $error("wait-state parameter does not fit in WS_W bits");
    end
    if ((NUM_CTRL < 1) || (NUM_CTRL > 4) || (ADDR_W != 16)) begin : g_bad_cfg
        $error("NUM_CTRL must be 1..4 and ADDR_W must be 16");
    end

    state_e          state_q, state_d;
    logic [15:0]     addr_q;
    logic            rwb_q;
    region_e         region_q, region_d;
    sel_t            sel_q, sel_d;
    logic [11:0]     off_q;
    logic            ack_q;
    logic [7:0]      rdata_q, rdata_d;
    logic            irq_q;
    logic [WS_W-1:0] ws_load;
    logic [WS_W-1:0] ws_count;
    logic            ws_zero;
    logic            load;
    logic            enter_ack;
    logic            irq_clr;

    assign load      = (state_q == ST_IDLE) && cpu_req;
    assign enter_ack = (state_q == ST_WAIT) && ws_zero;
    assign irq_clr   = enter_ack && !rwb_q && (addr_q == IO_IRQ);

    always_comb begin
        region_d = decode_region(cpu_address, NUM_CTRL);
        sel_d    = '0;
        ws_load  = '0;
        case (region_d)
            REG_RAM:  begin sel_d.ram  = 1'b1; ws_load = WS_W'(RAM_WS);  end
            REG_VRAM: begin sel_d.vram = 1'b1; ws_load = WS_W'(VRAM_WS); end
            REG_FW:   begin sel_d.fw   = 1'b1; ws_load = WS_W'(FW_WS);   end
            REG_IO:   begin sel_d.io   = 1'b1; ws_load = WS_W'(IO_WS);   end
            REG_ROM:  begin
                sel_d.rom = 1'b1;
                sel_d.vec = (cpu_address >= VEC_BASE);
                ws_load   = WS_W'(ROM_WS);
            end
            default:  begin sel_d = '0; ws_load = '0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cpu_req) state_d = ST_WAIT;
            ST_WAIT: if (ws_zero) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is produced from the latched address so a moving cpu_address
    // during the access cannot disturb it.
    always_comb begin
        rdata_d = 8'h00;
        if (rwb_q && (region_q == REG_IO)) begin
            if (addr_q == IO_BASE) begin
                rdata_d = {7'b0, in_vblank};
            end else if (addr_q == IO_IRQ) begin
                rdata_d = {7'b0, irq_q};
            end else begin
                for (int k = 0; k < NUM_CTRL; k++) begin
                    if (addr_q == IO_CTRL + 16'(k)) begin
                        rdata_d = controller_data[8*k +: 8];
                    end
                end
            end
        end
    end

    ws_counter_m #(.WS_W(WS_W)) u_ws_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (ws_load),
        .dec_i      (state_q == ST_WAIT),
        .count_o    (ws_count),
        .zero_o     (ws_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rwb_q    <= 1'b0;
            region_q <= REG_NONE;
            sel_q    <= '0;
            off_q    <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= enter_ack;
            if (load) begin
                addr_q   <= cpu_address;
                rwb_q    <= cpu_rwb;
                region_q <= region_d;
                sel_q    <= sel_d;
                off_q    <= cpu_address[11:0];
            end else if (state_q == ST_ACK) begin
                sel_q <= '0;
            end
            if (enter_ack) begin
                rdata_q <= rdata_d;
            end
            // A vblank arriving on the clearing edge must not be lost.
            irq_q <= vblank_start || (irq_q && !irq_clr);
        end
    end

`ifdef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (enter_ack && (region_q == REG_NONE)) begin
            err_q <= 1'b1;
        end else if (irq_clr) begin
            err_q <= 1'b0;
        end
    end
    assign bus_error = err_q;
`endif

    assign cpu_ack         = ack_q;
    assign io_rdata        = rdata_q;
    assign vram_offset     = off_q;
    assign SELECT_ram      = sel_q.ram;
    assign SELECT_vram     = sel_q.vram;
    assign SELECT_firmware = sel_q.fw;
    assign SELECT_rom      = sel_q.rom;
    assign SELECT_vectors  = sel_q.vec;
    assign SELECT_io       = sel_q.io;
    assign vblank_irq      = irq_q;

endmodule

// File: tb/tb_address_bus_ws_m.sv
// tb/tb_address_bus_ws_m.sv - self-checking bench for address_bus_ws_m (vectors, corner sequences, random vs model)
module tb_address_bus_ws_m;

    localparam int NUM_CTRL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_address;
    logic        cpu_rwb;
    logic        cpu_req;
    logic        cpu_ack;
    logic [7:0]  io_rdata;
    logic [11:0] vram_offset;
    logic        s_ram, s_vram, s_fw, s_rom, s_vec, s_io;
    logic        in_vblank;
    logic        vblank_start;
    logic [15:0] controller_data;
    logic        vblank_irq;
    logic        bus_error_w;

    address_bus_ws_m #(.NUM_CTRL(NUM_CTRL)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_address     (cpu_address),
        .cpu_rwb         (cpu_rwb),
        .cpu_req         (cpu_req),
        .cpu_ack         (cpu_ack),
        .io_rdata        (io_rdata),
        .vram_offset     (vram_offset),
        .SELECT_ram      (s_ram),
        .SELECT_vram     (s_vram),
        .SELECT_firmware (s_fw),
        .SELECT_rom      (s_rom),
        .SELECT_vectors  (s_vec),
        .SELECT_io       (s_io),
        .in_vblank       (in_vblank),
        .vblank_start    (vblank_start),
        .controller_data (controller_data),
`ifdef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
        .bus_error       (bus_error_w),
`endif
        .vblank_irq      (vblank_irq)
    );

`ifndef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
    assign bus_error_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic model_irq = 1'b0;
    logic model_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] get_sel();
        return {s_ram, s_vram, s_fw, s_rom, s_vec, s_io};
    endfunction

    // Reference map: {ram, vram, fw, rom, vectors, io}
    function automatic logic [5:0] m_sel(input logic [15:0] a);
        logic [5:0] s = 6'b0;
        if (a < 16'h4000)                  s[5] = 1'b1;
        else if (a < 16'h5000)             s[4] = 1'b1;
        else if (a < 16'h7000)             s[3] = 1'b1;
        else if (a < 16'h8000) begin
            if (int'(a) <= 'h7001 + NUM_CTRL) s[0] = 1'b1;
        end else begin
            s[2] = 1'b1;
            s[1] = (a >= 16'hFFFA);
        end
        return s;
    endfunction

    function automatic int m_lat(input logic [15:0] a);
        if (a >= 16'h8000) return 3;
        if (a >= 16'h4000 && a < 16'h5000) return 2;
        return 1;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [15:0] a);
        int k;
        if (a == 16'h7000) return {7'b0, in_vblank};
        if (a == 16'h7001) return {7'b0, model_irq};
        k = int'(a) - 'h7002;
        if (k >= 0 && k < NUM_CTRL) return 8'(controller_data >> (8 * k));
        return 8'h00;
    endfunction

    // One full access; returns after the edge that should drop the selects.
    task automatic access(input logic [15:0] a, input logic rwb, input logic [5:0] esel,
                          input int elat, input logic chk_rd, input logic [7:0] erd, input string tag);
        int k;
        cpu_address = a;
        cpu_rwb     = rwb;
        cpu_req     = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_noack_N"}, cpu_ack, 0);
        chk({tag, "_sel"}, get_sel(), esel);
        chk({tag, "_off"}, vram_offset, a[11:0]);
        cpu_address = ~a;
        k = 0;
        while (!cpu_ack && k < 10) begin
            @(posedge clk); #1;
            k++;
            if (get_sel() !== esel) chk({tag, "_sel_hold"}, get_sel(), esel);
        end
        chk({tag, "_lat"}, k, elat);
        if (chk_rd) chk({tag, "_rdata"}, io_rdata, erd);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_sel_drop"}, {get_sel(), cpu_ack}, 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rwb;
        logic        vbl;
        logic [5:0]  esel;
        int          elat;
        logic        chk_rd;
        logic [7:0]  erd;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{16'h9000, 1'b1, 1'b0, 6'b000100, 3, 1'b0, 8'h00};
        vt[1]  = '{16'hFFFC, 1'b1, 1'b0, 6'b000110, 3, 1'b0, 8'h00};
        vt[2]  = '{16'h4ABC, 1'b1, 1'b0, 6'b010000, 2, 1'b0, 8'h00};
        vt[3]  = '{16'h1234, 1'b0, 1'b0, 6'b100000, 1, 1'b0, 8'h00};
        vt[4]  = '{16'h3FFF, 1'b1, 1'b0, 6'b100000, 1, 1'b0, 8'h00};
        vt[5]  = '{16'h5000, 1'b1, 1'b0, 6'b001000, 1, 1'b0, 8'h00};
        vt[6]  = '{16'h6FFF, 1'b1, 1'b0, 6'b001000, 1, 1'b0, 8'h00};
        vt[7]  = '{16'h7002, 1'b1, 1'b0, 6'b000001, 1, 1'b1, 8'h5A};
        vt[8]  = '{16'h7003, 1'b1, 1'b0, 6'b000001, 1, 1'b1, 8'hA5};
        vt[9]  = '{16'h7004, 1'b1, 1'b0, 6'b000000, 1, 1'b1, 8'h00};
        vt[10] = '{16'h7000, 1'b1, 1'b1, 6'b000001, 1, 1'b1, 8'h01};
        vt[11] = '{16'hFFF9, 1'b1, 1'b0, 6'b000100, 3, 1'b0, 8'h00};
        vt[12] = '{16'h8000, 1'b1, 1'b0, 6'b000100, 3, 1'b0, 8'h00};

        rst = 1'b1;
        cpu_address = 16'h0000;
        cpu_rwb = 1'b1;
        cpu_req = 1'b1;
        in_vblank = 1'b0;
        vblank_start = 1'b0;
        controller_data = 16'hA55A;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {cpu_ack, get_sel(), vblank_irq, bus_error_w}, 0);
        chk("rst_data", {io_rdata, vram_offset}, 0);
        rst = 1'b0;
        access(16'h0000, 1'b1, 6'b100000, 1, 1'b0, 8'h00, "rst_ram");

        // Reset in the middle of a ROM access: no ack, selects cleared.
        cpu_address = 16'h9000;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_sel", get_sel(), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_noack", cpu_ack, 0);
        end
        cpu_req = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vt[i]) begin
            in_vblank = vt[i].vbl;
            access(vt[i].addr, vt[i].rwb, vt[i].esel, vt[i].elat, vt[i].chk_rd, vt[i].erd,
                   $sformatf("vec%0d", i));
        end
        in_vblank = 1'b0;

        // vblank IRQ set, read back, set-wins-over-clear, plain clear.
        vblank_start = 1'b1;
        @(posedge clk); #1;
        vblank_start = 1'b0;
        model_irq = 1'b1;
        chk("irq_set", vblank_irq, 1);
        access(16'h7001, 1'b1, 6'b000001, 1, 1'b1, 8'h01, "irq_read");

        cpu_address = 16'h7001;
        cpu_rwb = 1'b0;
        cpu_req = 1'b1;
        @(posedge clk); #1;
        vblank_start = 1'b1;
        @(posedge clk); #1;
        vblank_start = 1'b0;
        chk("irq_race_ack", cpu_ack, 1);
        chk("irq_race_keep", vblank_irq, 1);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("irq_race_after", vblank_irq, 1);

        access(16'h7800, 1'b1, 6'b000000, 1, 1'b1, 8'h00, "unmapped");
`ifdef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
        model_err = 1'b1;
`endif
        chk("trap_set", bus_error_w, model_err);
        access(16'h7001, 1'b0, 6'b000001, 1, 1'b0, 8'h00, "irq_clear");
        model_irq = 1'b0;
        model_err = 1'b0;
        chk("irq_cleared", vblank_irq, 0);
        chk("trap_cleared", bus_error_w, 0);

        // Random accesses against the reference map.
        for (int it = 0; it < 60; it++) begin
            logic [15:0] a;
            logic        rwb;
            if ($urandom_range(0, 3) == 0) begin
                vblank_start = 1'b1;
                @(posedge clk); #1;
                vblank_start = 1'b0;
                model_irq = 1'b1;
            end
            case ($urandom_range(0, 6))
                0: a = 16'($urandom_range(0, 'h3FFF));
                1: a = 16'($urandom_range('h4000, 'h4FFF));
                2: a = 16'($urandom_range('h5000, 'h6FFF));
                3: a = 16'($urandom_range('h7000, 'h7003));
                4: a = 16'($urandom_range('h7004, 'h7FFF));
                5: a = 16'($urandom_range('h8000, 'hFFFF));
                default: a = 16'($urandom_range('hFFF8, 'hFFFF));
            endcase
            rwb = 1'($urandom_range(0, 1));
            in_vblank = 1'($urandom_range(0, 1));
            controller_data = 16'($urandom);
            access(a, rwb, m_sel(a), m_lat(a), rwb, m_rdata(a), $sformatf("rnd%0d_%04h", it, a));
            if (!rwb && a == 16'h7001) begin
                model_irq = 1'b0;
                model_err = 1'b0;
            end
`ifdef MAPACHE64_ADDRESS_BUS_UNMAPPED_TRAP_EN
            if (m_sel(a) == 6'b0) model_err = 1'b1;
`endif
            chk("rnd_irq", vblank_irq, model_irq);
            chk("rnd_err", bus_error_w, model_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
